// File: rtl/conv_stream_tx.sv
// -----------------------------------------------------------------------------
// conv_stream_tx
//   Host-side initiator for the CONV nibble-stream port. Buffers one frame of
//   N_IN nibbles (8 x-samples then 8 h-samples), streams it into CONV under
//   busy back-pressure, counts the N_OUT returned results and pulses done.
//
//   Optional feature: define CONV_TX_CHKSUM_EN to build a 16-bit accumulator
//   of the returned conv_dout values on chk; otherwise chk is tied to zero.
//
// Ports
//   clk             in   single clock, posedge
//   reset           in   asynchronous active-low reset
//   ld_en/ld_data   in   host write strobe / nibble into the frame buffer
//   start           in   begin transmitting a full buffer
//   conv_busy       in   CONV busy (no nibble accepted this cycle)
//   conv_out_valid  in   CONV result strobe
//   conv_dout       in   CONV result value
//   Din/in_en       out  nibble and its valid towards CONV
//   full            out  buffer holds N_IN nibbles
//   active          out  frame in flight (SEND or WAIT)
//   done            out  one-cycle pulse after the last result
//   err_stray       out  sticky: result strobe seen while idle
//   chk             out  frame checksum (zero unless CONV_TX_CHKSUM_EN)
// -----------------------------------------------------------------------------
module conv_stream_tx #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_en,
  input  logic [3:0]  ld_data,
  input  logic        start,
  input  logic        conv_busy,
  input  logic        conv_out_valid,
  input  logic [7:0]  conv_dout,
  output logic [3:0]  Din,
  output logic        in_en,
  output logic        full,
  output logic        active,
  output logic        done,
  output logic        err_stray,
  output logic [15:0] chk
);

  localparam logic [4:0] LP_N_IN  = 5'(N_IN);
  localparam logic [4:0] LP_LAST  = 5'(N_IN - 1);
  localparam logic [3:0] LP_N_OUT = 4'(N_OUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_buf [N_IN];
  logic [4:0] r_wr_ptr;
  logic [4:0] r_rd_ptr;
  logic [3:0] r_res_cnt;
  logic       r_err_stray;

  logic w_load;
  logic w_start;
  logic w_xfer;
  logic w_count;
  logic w_last_xfer;
  logic w_res_done;

  // ---- control decode ------------------------------------------------------
  assign full    = (r_wr_ptr == LP_N_IN);
  assign w_load  = (r_state == S_IDLE) && ld_en && !full;
  assign w_start = (r_state == S_IDLE) && start && full;
  assign w_xfer  = (r_state == S_SEND) && !conv_busy;
  // Results are counted in SEND as well as WAIT; the counter stops at N_OUT
  // so late strobes in SEND cannot wrap it.
  assign w_count = ((r_state == S_SEND) || (r_state == S_WAIT)) &&
                   conv_out_valid && (r_res_cnt != LP_N_OUT);
  assign w_last_xfer = w_xfer && (r_rd_ptr == LP_LAST);
  // Result set is complete either already, or with this cycle's strobe.
  assign w_res_done  = (r_res_cnt == LP_N_OUT) ||
                       (w_count && (r_res_cnt == LP_N_OUT - 4'd1));

  // ---- next state / outputs ------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    in_en       = 1'b0;
    Din         = 4'h0;
    active      = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        active = 1'b1;
        in_en  = w_xfer;
        if (w_xfer) Din = r_buf[r_rd_ptr[3:0]];
        // A result set that completes early still waits for the last nibble.
        if (w_last_xfer) w_state_nxt = w_res_done ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        active = 1'b1;
        if (w_res_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- state and control registers -----------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_res_cnt   <= '0;
      r_err_stray <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_DONE)
        r_wr_ptr <= '0;
      else if (w_load)
        r_wr_ptr <= r_wr_ptr + 5'd1;

      if (w_start)
        r_rd_ptr <= '0;
      else if (w_xfer && (r_rd_ptr != LP_N_IN))
        r_rd_ptr <= r_rd_ptr + 5'd1;

      if (w_start)
        r_res_cnt <= '0;
      else if (w_count)
        r_res_cnt <= r_res_cnt + 4'd1;

      if ((r_state == S_IDLE) && conv_out_valid)
        r_err_stray <= 1'b1;
    end
  end

  assign err_stray = r_err_stray;

  // ---- frame buffer (data only, no reset) ----------------------------------
  always_ff @(posedge clk) begin
    if (w_load) r_buf[r_wr_ptr[3:0]] <= ld_data;
  end

  // ---- checksum ------------------------------------------------------------
`ifdef CONV_TX_CHKSUM_EN
  logic [15:0] r_chk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_chk <= '0;
    else if (w_start)
      r_chk <= '0;
    else if (w_count)
      r_chk <= r_chk + {8'h00, conv_dout};
  end

  assign chk = r_chk;
`else
  logic w_unused_dout;

  assign w_unused_dout = ^conv_dout;
  assign chk           = 16'h0000;
`endif

endmodule

// File: tb/tb_conv_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_conv_stream_tx
//   Randomized self-checking bench for conv_stream_tx. A queue-based model of
//   the frame (buffered nibbles, nibbles still to send, results received)
//   predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_conv_stream_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_data = 4'h0;
  logic        start = 1'b0;
  logic        conv_busy = 1'b0;
  logic        conv_out_valid = 1'b0;
  logic [7:0]  conv_dout = 8'h00;
  logic [3:0]  Din;
  logic        in_en;
  logic        full;
  logic        active;
  logic        done;
  logic        err_stray;
  logic [15:0] chk;

  conv_stream_tx #(.N_IN(16), .N_OUT(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .ld_en          (ld_en),
    .ld_data        (ld_data),
    .start          (start),
    .conv_busy      (conv_busy),
    .conv_out_valid (conv_out_valid),
    .conv_dout      (conv_dout),
    .Din            (Din),
    .in_en          (in_en),
    .full           (full),
    .active         (active),
    .done           (done),
    .err_stray      (err_stray),
    .chk            (chk)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [3:0]  m_frame[$];
  logic [3:0]  m_txq[$];
  bit          m_inflight;
  bit          m_done;
  bit          m_stray;
  int          m_res;
  logic [15:0] m_sum;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_txq.delete();
    m_inflight = 1'b0;
    m_done     = 1'b0;
    m_stray    = 1'b0;
    m_res      = 0;
    m_sum      = 16'h0;
  endtask

  task automatic check_outputs(input string where);
    logic       exp_en;
    logic [3:0] exp_din;
    logic [15:0] exp_chk;
    exp_en  = m_inflight && (m_txq.size() > 0) && !conv_busy;
    exp_din = exp_en ? m_txq[0] : 4'h0;
`ifdef CONV_TX_CHKSUM_EN
    exp_chk = m_sum;
`else
    exp_chk = 16'h0000;
`endif
    check_val({where, ".in_en"},     in_en,     exp_en);
    check_val({where, ".Din"},       Din,       exp_din);
    check_val({where, ".full"},      full,      m_frame.size() == 16);
    check_val({where, ".active"},    active,    m_inflight);
    check_val({where, ".done"},      done,      m_done);
    check_val({where, ".err_stray"}, err_stray, m_stray);
    check_val({where, ".chk"},       chk,       exp_chk);
  endtask

  // Apply the behaviour of one clock edge to the model.
  task automatic model_step(input bit le, input logic [3:0] ld, input bit st,
                            input bit bz, input bit ov, input logic [7:0] dv);
    if (m_done) begin
      m_done = 1'b0;
      m_frame.delete();
    end else if (!m_inflight) begin
      if (ov) m_stray = 1'b1;
      if (st && m_frame.size() == 16) begin
        m_inflight = 1'b1;
        m_txq      = m_frame;
        m_res      = 0;
        m_sum      = 16'h0;
      end else if (le && m_frame.size() < 16) begin
        m_frame.push_back(ld);
      end
    end else begin
      if (m_txq.size() > 0 && !bz) void'(m_txq.pop_front());
      if (ov && m_res < 15) begin
        m_res++;
        m_sum = m_sum + {8'h00, dv};
      end
      if (m_txq.size() == 0 && m_res == 15) begin
        m_inflight = 1'b0;
        m_done     = 1'b1;
      end
    end
  endtask

  // One clock: drive after the edge, check at negedge, model at posedge.
  task automatic cycle(input bit le, input logic [3:0] ld, input bit st,
                       input bit bz, input bit ov, input logic [7:0] dv);
    ld_en = le; ld_data = ld; start = st;
    conv_busy = bz; conv_out_valid = ov; conv_dout = dv;
    @(negedge clk);
    check_outputs("cyc");
    @(posedge clk);
    model_step(le, ld, st, bz, ov, dv);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 4'($urandom), 1'b0, 1'($urandom), 1'b0, 8'h00);
  endtask

  // Run a started frame to completion with random back-pressure, result
  // strobes and ignored host noise.
  task automatic run_frame(input int busy_pct, input int ov_pct, input bit alt_busy);
    int k;
    bit bz;
    k = 0;
    while ((m_inflight || m_done) && k < 400) begin
      bz = alt_busy ? k[0] : (int'($urandom_range(99)) < busy_pct);
      cycle(1'($urandom), 4'($urandom), 1'($urandom), bz,
            int'($urandom_range(99)) < ov_pct, 8'($urandom));
      k++;
    end
    check_val("frame_end.active", active, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Ordered frame 1..F,0 with no back-pressure, then 15 results of 0x10.
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_val("wait.active", active, 1'b1);
    check_val("wait.in_en", in_en, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h10);
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    idle(2);
    check_val("after_done.full", full, 1'b0);
`ifdef CONV_TX_CHKSUM_EN
    check_val("sum_0x10", chk, 16'h00F0);
`endif

    // Start with a partial buffer is ignored; ld_en during SEND is ignored.
    load_random(10);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_val("partial_start.active", active, 1'b0);
    load_random(6);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_frame(0, 20, 1'b1);
    idle(2);

    // Random frames with random back-pressure and result timing.
    for (int f = 0; f < 6; f++) begin
      load_random(16);
      cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
      run_frame(30, 10 + 10 * f, 1'b0);
      idle(1);
    end

    // Stray result strobe in IDLE is sticky.
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h55);
    idle(3);
    check_val("stray.sticky", err_stray, 1'b1);
    load_random(16);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_frame(20, 40, 1'b0);

    // Asynchronous reset in SEND after 7 transfers.
    load_random(16);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_val("pre_rst.in_en", in_en, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Recovery after reset.
    load_random(16);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_frame(25, 50, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
